// File: rtl/cell_dispatch_pkg.sv
// Shared types for the cell processing pipeline: cells, opcodes, operand
// select and the operand bundle handed to the cell processor.
package CellProcessingPkg;

  localparam int unsigned DISPATCH_DEPTH = 4;

  typedef enum logic {
    OPERAND_A = 1'b0,
    OPERAND_B = 1'b1
  } operand_sel_t;

  typedef struct packed {
    logic [3:0]  tag;
    logic [11:0] payload;
  } cell_t;

  typedef logic [7:0] userInput_t;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_MUL = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6
  } opcodes_t;

  typedef struct packed {
    cell_t      cellA;
    cell_t      cellB;
    userInput_t userInputA;
    opcodes_t   opcode;
  } cellProcessor_t;

endpackage

// File: rtl/cell_dispatch_fifo.sv
// Power-of-two deep cell queue; push is refused when full, pop when empty.
module cell_fifo
  import CellProcessingPkg::*;
#(
  parameter int unsigned DEPTH = DISPATCH_DEPTH,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  cell_t         push_data,
  input  logic          pop,
  output cell_t         data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  cell_t         mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign data    = mem[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/cell_dispatch.sv
// Pairs cells from operand queues A and B in order and presents them, with
// the current shadow configuration, to the cell processor through a
// valid/ready output register.
module cell_dispatch
  import CellProcessingPkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DISPATCH_DEPTH,
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  cell_t         in_cell,
  input  operand_sel_t  in_sel,
  input  logic          cfg_we,
  input  opcodes_t      cfg_opcode,
  input  userInput_t    cfg_user,
  output logic          out_valid,
  input  logic          out_ready,
  output cell_t         cellA,
  output cell_t         cellB,
  output userInput_t    userInputA,
  output opcodes_t      opcode,
  output logic [CW-1:0] countA,
  output logic [CW-1:0] countB,
  output logic [15:0]   dispatch_count
);

  cellProcessor_t cellProcessor_int;
  logic           out_valid_q;
  logic [15:0]    dispatch_count_q;
  opcodes_t       shadow_opcode_q;
  userInput_t     shadow_user_q;

  cell_t head_a, head_b;
  logic  full_a, full_b, empty_a, empty_b;
  logic  push_a, push_b, load;

  assign in_ready = rst && !((in_sel == OPERAND_A) ? full_a : full_b);
  assign push_a   = in_valid && in_ready && (in_sel == OPERAND_A);
  assign push_b   = in_valid && in_ready && (in_sel == OPERAND_B);
  assign load     = !empty_a && !empty_b && (!out_valid_q || out_ready);

  cell_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (push_a),
    .push_data (in_cell),
    .pop       (load),
    .data      (head_a),
    .count     (countA),
    .full      (full_a),
    .empty     (empty_a)
  );

  cell_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (push_b),
    .push_data (in_cell),
    .pop       (load),
    .data      (head_b),
    .count     (countB),
    .full      (full_b),
    .empty     (empty_b)
  );

  // Shadow config is sampled at load, so a write in the load cycle hits the next pair.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cellProcessor_int <= '{cellA: '0, cellB: '0, userInputA: '0, opcode: OP_NOP};
      out_valid_q       <= 1'b0;
      dispatch_count_q  <= '0;
      shadow_opcode_q   <= OP_NOP;
      shadow_user_q     <= '0;
    end else begin
      if (cfg_we) begin
        shadow_opcode_q <= cfg_opcode;
        shadow_user_q   <= cfg_user;
      end
      if (load) begin
        cellProcessor_int <= '{cellA: head_a, cellB: head_b,
                               userInputA: shadow_user_q, opcode: shadow_opcode_q};
        out_valid_q       <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (out_valid_q && out_ready) dispatch_count_q <= dispatch_count_q + 16'd1;
    end
  end

  assign out_valid      = out_valid_q;
  assign dispatch_count = dispatch_count_q;
  assign cellA          = cellProcessor_int.cellA;
  assign cellB          = cellProcessor_int.cellB;
  assign userInputA     = cellProcessor_int.userInputA;
  assign opcode         = cellProcessor_int.opcode;

endmodule

// File: tb/tb_cell_dispatch.sv
// Directed bench for cell_dispatch: ordering, full, backpressure, config
// timing, wrap and mid-transfer reset.
module tb_cell_dispatch;
  import CellProcessingPkg::*;

  localparam int unsigned CW = $clog2(DISPATCH_DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  cell_t         in_cell;
  operand_sel_t  in_sel;
  logic          cfg_we;
  opcodes_t      cfg_opcode;
  userInput_t    cfg_user;
  logic          out_valid;
  logic          out_ready;
  cell_t         cellA, cellB;
  userInput_t    userInputA;
  opcodes_t      opcode;
  logic [CW-1:0] countA, countB;
  logic [15:0]   dispatch_count;

  int tests = 0;
  int fails = 0;

  cell_dispatch #(.FIFO_DEPTH(DISPATCH_DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_cell        (in_cell),
    .in_sel         (in_sel),
    .cfg_we         (cfg_we),
    .cfg_opcode     (cfg_opcode),
    .cfg_user       (cfg_user),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .cellA          (cellA),
    .cellB          (cellB),
    .userInputA     (userInputA),
    .opcode         (opcode),
    .countA         (countA),
    .countB         (countB),
    .dispatch_count (dispatch_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_cell(input operand_sel_t sel, input logic [15:0] c);
    in_valid = 1'b1;
    in_sel   = sel;
    in_cell  = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
    tests++; if (countA !== '0 || countB !== '0) begin fails++; $display("FAIL reset_counts got %0d/%0d want 0/0", countA, countB); end
    tests++; if (dispatch_count !== 16'd0) begin fails++; $display("FAIL reset_dcount got %h want 0000", dispatch_count); end
    tests++; if (cellA !== 16'h0 || cellB !== 16'h0 || userInputA !== 8'h0 || opcode !== OP_NOP) begin
      fails++; $display("FAIL reset_fields got %h %h %h %0d want zeros", cellA, cellB, userInputA, opcode); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ordering();
    out_ready = 1'b1;
    push_cell(OPERAND_A, 16'hA000);
    push_cell(OPERAND_A, 16'hA001);
    push_cell(OPERAND_B, 16'hB000);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL latency_valid got %b want 0", out_valid); end
    push_cell(OPERAND_B, 16'hB001);
    tests++; if (out_valid !== 1'b1 || cellA !== 16'hA000 || cellB !== 16'hB000) begin
      fails++; $display("FAIL order_pair0 got %b %h %h want 1 a000 b000", out_valid, cellA, cellB); end
    tick();
    tests++; if (out_valid !== 1'b1 || cellA !== 16'hA001 || cellB !== 16'hB001) begin
      fails++; $display("FAIL order_pair1 got %b %h %h want 1 a001 b001", out_valid, cellA, cellB); end
    tick();
    tests++; if (out_valid !== 1'b0 || dispatch_count !== 16'd2) begin
      fails++; $display("FAIL order_drain got %b %0d want 0 2", out_valid, dispatch_count); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) push_cell(OPERAND_A, 16'hA010 + 16'(i));
    tests++; if (countA !== CW'(4)) begin fails++; $display("FAIL full_count got %0d want 4", countA); end
    in_sel = OPERAND_A;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_ready_a got %b want 0", in_ready); end
    in_sel = OPERAND_B;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_ready_b got %b want 1", in_ready); end
    push_cell(OPERAND_A, 16'hA014);
    tests++; if (countA !== CW'(4)) begin fails++; $display("FAIL full_refuse got %0d want 4", countA); end
    for (int i = 0; i < 4; i++) push_cell(OPERAND_B, 16'hB010 + 16'(i));
    tick();
    tests++; if (cellA !== 16'hA013 || cellB !== 16'hB013 || countA !== '0) begin
      fails++; $display("FAIL full_last got %h %h %0d want a013 b013 0", cellA, cellB, countA); end
    tick();
    tests++; if (out_valid !== 1'b0 || dispatch_count !== 16'd6) begin
      fails++; $display("FAIL full_drain got %b %0d want 0 6", out_valid, dispatch_count); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push_cell(OPERAND_A, 16'hA020);
    push_cell(OPERAND_A, 16'hA021);
    push_cell(OPERAND_B, 16'hB020);
    push_cell(OPERAND_B, 16'hB021);
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (out_valid !== 1'b1 || cellA !== 16'hA020 || cellB !== 16'hB020 || countA !== CW'(1)) begin
        fails++; $display("FAIL bp_hold got %b %h %h %0d want 1 a020 b020 1", out_valid, cellA, cellB, countA); end
    end
    out_ready = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b1 || cellA !== 16'hA021 || cellB !== 16'hB021) begin
      fails++; $display("FAIL bp_release got %b %h %h want 1 a021 b021", out_valid, cellA, cellB); end
    tick();
    tests++; if (dispatch_count !== 16'd8) begin fails++; $display("FAIL bp_dcount got %0d want 8", dispatch_count); end
  endtask

  task automatic test_config();
    out_ready = 1'b0;
    push_cell(OPERAND_A, 16'hA030);
    push_cell(OPERAND_A, 16'hA031);
    push_cell(OPERAND_B, 16'hB030);
    push_cell(OPERAND_B, 16'hB031);
    cfg_we = 1'b1; cfg_opcode = OP_XOR; cfg_user = 8'h5A;
    tick();
    cfg_we = 1'b0;
    tests++; if (opcode !== OP_NOP || userInputA !== 8'h00 || cellA !== 16'hA030) begin
      fails++; $display("FAIL cfg_old got %0d %h %h want 0 00 a030", opcode, userInputA, cellA); end
    out_ready = 1'b1;
    tick();
    tests++; if (opcode !== OP_XOR || userInputA !== 8'h5A || cellA !== 16'hA031) begin
      fails++; $display("FAIL cfg_new got %0d %h %h want 6 5a a031", opcode, userInputA, cellA); end
    tick();
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      push_cell(OPERAND_A, 16'hA100 + 16'(k));
      push_cell(OPERAND_B, 16'hB100 + 16'(k));
      tick();
      tests++; if (out_valid !== 1'b1 || cellA !== 16'hA100 + 16'(k) || cellB !== 16'hB100 + 16'(k)) begin
        fails++; $display("FAIL wrap_pair%0d got %b %h %h", k, out_valid, cellA, cellB); end
    end
    tick();
    tests++; if (dispatch_count !== 16'd20 || out_valid !== 1'b0) begin
      fails++; $display("FAIL wrap_dcount got %0d %b want 20 0", dispatch_count, out_valid); end
  endtask

  task automatic test_count_wrap();
    // Preload stands in for 65534 earlier handshakes.
    dut.dispatch_count_q = 16'hFFFE;
    out_ready = 1'b1;
    push_cell(OPERAND_A, 16'hA040);
    push_cell(OPERAND_A, 16'hA041);
    push_cell(OPERAND_B, 16'hB040);
    push_cell(OPERAND_B, 16'hB041);
    tick();
    tests++; if (dispatch_count !== 16'hFFFF) begin fails++; $display("FAIL dcount_max got %h want ffff", dispatch_count); end
    tick();
    tests++; if (dispatch_count !== 16'h0000) begin fails++; $display("FAIL dcount_wrap got %h want 0000", dispatch_count); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_cell(OPERAND_A, 16'hA050 + 16'(i));
    for (int i = 0; i < 3; i++) push_cell(OPERAND_B, 16'hB050 + 16'(i));
    tests++; if (countA !== CW'(3) || countB !== CW'(2) || out_valid !== 1'b1) begin
      fails++; $display("FAIL mid_pre got %0d %0d %b want 3 2 1", countA, countB, out_valid); end
    rst = 1'b0;
    tick();
    tests++; if (countA !== '0 || countB !== '0 || out_valid !== 1'b0 || dispatch_count !== 16'd0) begin
      fails++; $display("FAIL mid_counts got %0d %0d %b %0d want 0 0 0 0", countA, countB, out_valid, dispatch_count); end
    tests++; if (cellA !== 16'h0 || cellB !== 16'h0 || userInputA !== 8'h0 || opcode !== OP_NOP) begin
      fails++; $display("FAIL mid_fields got %h %h %h %0d want zeros", cellA, cellB, userInputA, opcode); end
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_after got %b want 0", out_valid); end
    push_cell(OPERAND_A, 16'hA060);
    push_cell(OPERAND_B, 16'hB060);
    tick();
    tests++; if (cellA !== 16'hA060 || opcode !== OP_NOP || userInputA !== 8'h00) begin
      fails++; $display("FAIL mid_shadow got %h %0d %h want a060 0 00", cellA, opcode, userInputA); end
  endtask

  initial begin
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_cell    = '0;
    in_sel     = OPERAND_A;
    cfg_we     = 1'b0;
    cfg_opcode = OP_NOP;
    cfg_user   = '0;
    out_ready  = 1'b0;
    @(negedge clk);
    test_reset();
    test_ordering();
    test_full();
    test_backpressure();
    test_config();
    test_wrap();
    test_count_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
